calculator_controller: RTL and testbench
========================================

Name: calculator_controller

Overview:
FSM that sequences one calculator job through a single-port SRAM, the adder, and the 64-bit result buffer. Each memory word holds an operand pair; the block feeds each pair to the adder and steers two consecutive sums into the buffer halves via loc_sel. It then writes the filled buffer back to a separate address range. Sits between the top-level start/done interface, the SRAM, and the result buffer.

Parameters:
DATA_W, 32, operand/result width (from calculator_pkg)
MEM_WORD_SIZE, 64, SRAM word and buffer width (from calculator_pkg)
ADDR_W, 10, SRAM address width (from calculator_pkg)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  job start pulse, sampled only in S_IDLE
read_start_addr_i  in  ADDR_W  first operand word
read_end_addr_i  in  ADDR_W  last operand word (inclusive)
write_start_addr_i  in  ADDR_W  first result word
write_end_addr_i  in  ADDR_W  last result word (inclusive)
read_en_o  out  1  SRAM read strobe, 1-cycle read latency
write_en_o  out  1  SRAM write strobe
addr_o  out  ADDR_W  SRAM address (read or write)
read_data_i  in  MEM_WORD_SIZE  SRAM read data
write_data_o  out  MEM_WORD_SIZE  SRAM write data, equals buffer_i
op_a_o  out  DATA_W  adder operand A
op_b_o  out  DATA_W  adder operand B
loc_sel_o  out  1  result buffer half select: 0 = [31:0], 1 = [63:32]
buffer_i  in  MEM_WORD_SIZE  result buffer contents
busy_o  out  1  high in every state except S_IDLE
done_o  out  1  one-cycle pulse at job end
error_o  out  1  one-cycle pulse with done_o on an illegal range

Behaviour:
- Reset (async assert, sync release): state = S_IDLE, all pointers = 0, half = 0, all outputs = 0.
- Registers: rd_ptr, rd_end, wr_ptr, wr_end, half.
- S_IDLE: if start_i, latch the four addresses and set half = 0.
  - If read_start > read_end or write_start > write_end, go to S_DONE with error_o.
  - Otherwise go to S_READ.
- S_READ: read_en_o = 1, addr_o = rd_ptr. Go to S_ADD.
- S_ADD (read_data_i valid):
  - op_a_o = read_data_i[31:0], op_b_o = read_data_i[63:32], loc_sel_o = half. The buffer captures the sum at this edge.
  - If half = 0 and rd_ptr != rd_end: half <= 1, rd_ptr++, go to S_READ.
  - If half = 0 and rd_ptr == rd_end (odd count): go to S_PAD.
  - If half = 1: go to S_WRITE.
- S_PAD: op_a_o = op_b_o = 0, loc_sel_o = 1, which zeroes the upper half. Go to S_WRITE.
- S_WRITE: write_en_o = 1, addr_o = wr_ptr, write_data_o = buffer_i.
  - If rd_ptr == rd_end or wr_ptr == wr_end: go to S_DONE.
  - Otherwise: rd_ptr++, wr_ptr++, half <= 0, go to S_READ.
- S_DONE: done_o = 1 (error_o = 1 if entered on a range error). Go to S_IDLE.
- Outside their active states, op_a_o, op_b_o, loc_sel_o, read_en_o and write_en_o are 0. read_en_o and write_en_o are never high together.
- Latency: for N (even) read words, the done_o pulse arrives 5·N/2 + 1 cycles after the start cycle. An odd N costs 1 extra cycle for S_PAD.
- Truncation: if the write range is shorter than needed, the job ends after writing wr_end; remaining operands are ignored.
- Address pointers never wrap; a range ending at 2^ADDR_W−1 is legal because the end test uses equality.
- start_i while busy is ignored.
- Asserting rst_i mid-job aborts immediately with no further SRAM strobes. The result buffer reset is owned by the top level.
- Sum overflow wraps modulo 2^32 and is the adder's concern.

Decomposition:
- calculator_pkg: ADDR_W, DATA_W, MEM_WORD_SIZE, and typedef enum logic [2:0] controller_state_e {S_IDLE, S_READ, S_ADD, S_PAD, S_WRITE, S_DONE}.
- No sub-module. The adder and result_buffer are instantiated by the top level alongside this block.

Test Plan:
- Two-word job:
  - Setup: mem[0] = {32'd5, 32'd3}, mem[1] = {32'd20, 32'd10}, read 0..1, write 512..512.
  - Expected: mem[512] = 64'h0000001E_00000008; done_o exactly 6 cycles after start; error_o = 0.
- Odd count:
  - Setup: read 0..2 (mem[2] = {32'd1, 32'd1}), write 512..513.
  - Expected: mem[513] = 64'h00000000_00000002; S_PAD visited once.
- Range error: read_start = 4, read_end = 3 → done_o and error_o high on the same cycle, 1 cycle after start; no read_en_o or write_en_o ever asserted.
- Truncation and wrap:
  - Setup: read 0..3, write 600..600, mem[0] = {32'hFFFFFFFF, 32'h1}.
  - Expected: only mem[600] written, lower half = 0; done_o after 6 cycles.
- Reset mid-job: assert rst_i during the second S_READ → all outputs 0 in the same cycle; a new start_i after release runs a full job correctly.
- Busy start: pulse start_i with different addresses during S_ADD → ignored; the original job's results are unchanged.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared widths, controller state encoding and address-range helper for the calculator datapath.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ADD,
        S_PAD,
        S_WRITE,
        S_DONE
    } controller_state_e;

    // Ranges are inclusive; only an inverted range is illegal, so a range may end at the top address.
    function automatic logic range_bad(input logic [ADDR_W-1:0] first, input logic [ADDR_W-1:0] last);
        return first > last;
    endfunction

endpackage

// File: rtl/calculator_controller.sv
// Sequences one calculator job: reads operand pairs from SRAM, steers two sums into the
// result buffer halves, then writes each filled buffer word back to the result range.
module calculator_controller
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr_i,
    input  logic [ADDR_W-1:0]        read_end_addr_i,
    input  logic [ADDR_W-1:0]        write_start_addr_i,
    input  logic [ADDR_W-1:0]        write_end_addr_i,
    output logic                     read_en_o,
    output logic                     write_en_o,
    output logic [ADDR_W-1:0]        addr_o,
    input  logic [MEM_WORD_SIZE-1:0] read_data_i,
    output logic [MEM_WORD_SIZE-1:0] write_data_o,
    output logic [DATA_W-1:0]        op_a_o,
    output logic [DATA_W-1:0]        op_b_o,
    output logic                     loc_sel_o,
    input  logic [MEM_WORD_SIZE-1:0] buffer_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);

    controller_state_e state_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_end;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_end;
    logic              half;
    logic              in_add;

    // Read data only exists in the cycle after the read strobe, so operands pass straight through.
    assign in_add       = (state_q == S_ADD);
    assign op_a_o       = in_add ? read_data_i[DATA_W-1:0]             : '0;
    assign op_b_o       = in_add ? read_data_i[MEM_WORD_SIZE-1:DATA_W] : '0;
    assign write_data_o = buffer_i;

    // Strobes, address and select are registered: each is set on the edge entering its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rd_ptr     <= '0;
            rd_end     <= '0;
            wr_ptr     <= '0;
            wr_end     <= '0;
            half       <= 1'b0;
            read_en_o  <= 1'b0;
            write_en_o <= 1'b0;
            addr_o     <= '0;
            loc_sel_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            read_en_o  <= 1'b0;
            write_en_o <= 1'b0;
            addr_o     <= '0;
            loc_sel_o  <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rd_ptr <= read_start_addr_i;
                        rd_end <= read_end_addr_i;
                        wr_ptr <= write_start_addr_i;
                        wr_end <= write_end_addr_i;
                        half   <= 1'b0;
                        busy_o <= 1'b1;
                        if (range_bad(read_start_addr_i, read_end_addr_i) ||
                            range_bad(write_start_addr_i, write_end_addr_i)) begin
                            state_q <= S_DONE;
                            done_o  <= 1'b1;
                            error_o <= 1'b1;
                        end else begin
                            state_q   <= S_READ;
                            read_en_o <= 1'b1;
                            addr_o    <= read_start_addr_i;
                        end
                    end
                end

                S_READ: begin
                    state_q   <= S_ADD;
                    loc_sel_o <= half;
                end

                S_ADD: begin
                    if (!half && (rd_ptr != rd_end)) begin
                        half      <= 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                        state_q   <= S_READ;
                        read_en_o <= 1'b1;
                        addr_o    <= rd_ptr + 1'b1;
                    end else if (!half) begin
                        // Odd operand count: one extra add of zeros clears the upper half.
                        state_q   <= S_PAD;
                        loc_sel_o <= 1'b1;
                    end else begin
                        state_q    <= S_WRITE;
                        write_en_o <= 1'b1;
                        addr_o     <= wr_ptr;
                    end
                end

                S_PAD: begin
                    state_q    <= S_WRITE;
                    write_en_o <= 1'b1;
                    addr_o     <= wr_ptr;
                end

                S_WRITE: begin
                    if ((rd_ptr == rd_end) || (wr_ptr == wr_end)) begin
                        state_q <= S_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        wr_ptr    <= wr_ptr + 1'b1;
                        half      <= 1'b0;
                        state_q   <= S_READ;
                        read_en_o <= 1'b1;
                        addr_o    <= rd_ptr + 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_controller.sv
// Bench for calculator_controller: SRAM, adder and result buffer models around the DUT,
// directed and randomized jobs checked against a pair-by-pair reference of the job's results.
module tb_calculator_controller;
    import calculator_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic                     start_i = 1'b0;
    logic [ADDR_W-1:0]        read_start_addr_i = '0;
    logic [ADDR_W-1:0]        read_end_addr_i = '0;
    logic [ADDR_W-1:0]        write_start_addr_i = '0;
    logic [ADDR_W-1:0]        write_end_addr_i = '0;
    logic                     read_en_o;
    logic                     write_en_o;
    logic [ADDR_W-1:0]        addr_o;
    logic [MEM_WORD_SIZE-1:0] read_data_i;
    logic [MEM_WORD_SIZE-1:0] write_data_o;
    logic [DATA_W-1:0]        op_a_o;
    logic [DATA_W-1:0]        op_b_o;
    logic                     loc_sel_o;
    logic [MEM_WORD_SIZE-1:0] buffer_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     error_o;

    int checks = 0;
    int failures = 0;

    calculator_controller dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .read_start_addr_i  (read_start_addr_i),
        .read_end_addr_i    (read_end_addr_i),
        .write_start_addr_i (write_start_addr_i),
        .write_end_addr_i   (write_end_addr_i),
        .read_en_o          (read_en_o),
        .write_en_o         (write_en_o),
        .addr_o             (addr_o),
        .read_data_i        (read_data_i),
        .write_data_o       (write_data_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .loc_sel_o          (loc_sel_o),
        .buffer_i           (buffer_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .error_o            (error_o)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model with 1-cycle read latency and a bench-side preload port.
    logic [63:0] mem [1024];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [63:0] pre_data = '0;
    typedef struct { logic [9:0] a; logic [63:0] d; } wr_t;
    wr_t wlog[$];

    always @(posedge clk_i) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (write_en_o) begin
            mem[addr_o] <= write_data_o;
            wlog.push_back('{a: addr_o, d: write_data_o});
        end
        if (read_en_o) read_data_i <= mem[addr_o];
    end

    // Adder + result buffer glue: capture in the cycle after a read, or whenever the upper half is selected.
    logic prev_rd;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buffer_i <= '0;
            prev_rd  <= 1'b0;
        end else begin
            prev_rd <= read_en_o;
            if (prev_rd || loc_sel_o) begin
                if (loc_sel_o) buffer_i[63:32] <= op_a_o + op_b_o;
                else           buffer_i[31:0]  <= op_a_o + op_b_o;
            end
        end
    end

    int rd_cnt = 0;
    int wr_cnt = 0;
    int ovl_cnt = 0;
    always @(negedge clk_i) begin
        if (read_en_o) rd_cnt <= rd_cnt + 1;
        if (write_en_o) wr_cnt <= wr_cnt + 1;
        if (read_en_o && write_en_o) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [63:0] d);
        @(negedge clk_i);
        pre_we = 1'b1; pre_addr = 10'(a); pre_data = d;
        @(negedge clk_i);
        pre_we = 1'b0;
    endtask

    function automatic logic [31:0] pair_sum(input logic [63:0] w);
        return w[31:0] + w[63:32];
    endfunction

    // Reference: result word k holds the sums of operand words 2k and 2k+1 (zero if absent);
    // a full pair costs 5 cycles, a lone word 4, and the done cycle 1; output stops at the write range end.
    wr_t exp_q[$];
    task automatic model(input int rs, input int re, input int ws, input int we,
                         output int lat, output bit err);
        int p;
        int w;
        logic [31:0] lo;
        logic [31:0] hi;
        exp_q.delete();
        lat = 1;
        err = (rs > re) || (ws > we);
        if (err) return;
        p = rs;
        w = ws;
        forever begin
            lo = pair_sum(mem[p]);
            if (p < re) begin
                hi = pair_sum(mem[p + 1]);
                lat += 5;
                p += 2;
            end else begin
                hi = '0;
                lat += 4;
                p += 1;
            end
            exp_q.push_back('{a: 10'(w), d: {hi, lo}});
            if (p > re || w == we) break;
            w++;
        end
    endtask

    task automatic run_job(input int rs, input int re, input int ws, input int we, input int poke);
        int lat;
        bit err;
        int c;
        int w0;
        int r0;
        int s0;
        int o0;
        model(rs, re, ws, we, lat, err);
        @(negedge clk_i);
        w0 = wlog.size(); r0 = rd_cnt; s0 = wr_cnt; o0 = ovl_cnt;
        read_start_addr_i = 10'(rs); read_end_addr_i = 10'(re);
        write_start_addr_i = 10'(ws); write_end_addr_i = 10'(we);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        c = 1;
        while (!done_o && c < 100) begin
            if (c == poke) begin
                start_i = 1'b1;
                read_start_addr_i = 10'd5; read_end_addr_i = 10'd6;
                write_start_addr_i = 10'd530; write_end_addr_i = 10'd530;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            c++;
        end
        chk("done_seen", 64'(done_o), 64'd1);
        chk("latency", 64'(c), 64'(lat));
        chk("error_flag", 64'(error_o), 64'(err));
        chk("busy_at_done", 64'(busy_o), 64'd1);
        chk("write_count", 64'(wlog.size() - w0), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (w0 + i < wlog.size()) begin
                chk("write_addr", 64'(wlog[w0 + i].a), 64'(exp_q[i].a));
                chk("write_data", wlog[w0 + i].d, exp_q[i].d);
            end
        end
        if (err) begin
            chk("err_no_read", 64'(rd_cnt - r0), 64'd0);
            chk("err_no_write", 64'(wr_cnt - s0), 64'd0);
        end
        chk("strobe_overlap", 64'(ovl_cnt - o0), 64'd0);
        @(negedge clk_i);
        chk("idle_done_low", 64'(done_o), 64'd0);
        chk("idle_busy_low", 64'(busy_o), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, 64'(read_en_o), 64'd0);
        chk({tag, "_wr"}, 64'(write_en_o), 64'd0);
        chk({tag, "_addr"}, 64'(addr_o), 64'd0);
        chk({tag, "_opa"}, 64'(op_a_o), 64'd0);
        chk({tag, "_opb"}, 64'(op_b_o), 64'd0);
        chk({tag, "_sel"}, 64'(loc_sel_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_err"}, 64'(error_o), 64'd0);
    endtask

    initial begin
        int rs;
        int n;
        int ws;
        int wn;
        int nw;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset");
        rst_i = 1'b0;

        // Two-word job
        load(0, {32'd5, 32'd3});
        load(1, {32'd20, 32'd10});
        run_job(0, 1, 512, 512, -1);
        chk("two_word_result", mem[512], 64'h0000001E_00000008);

        // Odd count
        load(2, {32'd1, 32'd1});
        run_job(0, 2, 512, 513, -1);
        chk("odd_pad_result", mem[513], 64'h00000000_00000002);

        // Range error
        run_job(4, 3, 512, 512, -1);

        // Truncation with sum wrap
        load(0, {32'hFFFFFFFF, 32'h1});
        load(3, {32'd7, 32'd9});
        run_job(0, 3, 600, 600, -1);
        chk("trunc_low_wrap", 64'(mem[600][31:0]), 64'd0);
        chk("trunc_no_601", mem[601], 64'd0);

        // Reset during the second read
        @(negedge clk_i);
        nw = wlog.size();
        read_start_addr_i = 10'd0; read_end_addr_i = 10'd3;
        write_start_addr_i = 10'd512; write_end_addr_i = 10'd513;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("second_read_strobe", 64'(read_en_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk_all_zero("midjob_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_no_writes", 64'(wlog.size() - nw), 64'd0);
        run_job(0, 3, 512, 513, -1);

        // Start while busy must be ignored
        load(5, {32'd100, 32'd200});
        load(6, {32'd300, 32'd400});
        run_job(0, 1, 520, 520, 2);

        // Read range ending at the top address
        load(1021, {$urandom, $urandom});
        load(1022, {$urandom, $urandom});
        load(1023, {$urandom, $urandom});
        run_job(1021, 1023, 700, 701, -1);

        // Randomized jobs, including truncation and an illegal write range
        for (int j = 0; j < 8; j++) begin
            rs = $urandom_range(0, 200);
            n  = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) load(rs + k, {$urandom, $urandom});
            ws = $urandom_range(512, 900);
            wn = $urandom_range(1, 4);
            if (j == 5) run_job(rs, rs + n - 1, ws, ws - 1, -1);
            else        run_job(rs, rs + n - 1, ws, ws + wn - 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
